// File: rtl/hex7seg_scan_mux.sv
// hex7seg_scan_mux
// Time-multiplexed driver for NUM_DIGITS seven-segment digits that share one
// segment bus. A free-running prescaler sets the slot length. A scan counter
// selects the digit. A double buffer only swaps at the end of a frame, so a
// frame never mixes old and new values. Each slot starts with a few clocks of
// all-anodes-off to hide ghosting while the segment bus settles.
//
// Optional build macro: HEX7SEG_LZ_BLANK_EN
//   When defined, leading zeros are suppressed. A digit goes dark when its
//   nibble and every higher nibble are zero. Digit 0 always shows. A set
//   decimal point keeps its own digit and all lower digits visible.
//   When undefined, no suppression logic is built.
module hex7seg_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV_BITS   = 16,
  parameter int BLANK_CYCLES   = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] x,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              a_to_g,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int                      IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CLK_DIV_BITS-1:0] BLANK_LIM = CLK_DIV_BITS'(BLANK_CYCLES);
  localparam logic [6:0]              SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic                    DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0]   AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // Active-high segment pattern for one hex nibble (bit6 = a ... bit0 = g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Apply the board's segment polarity to an active-high pattern.
  function automatic logic [6:0] seg_drive(input logic [6:0] seg_hi);
    return SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
  endfunction

  // Apply the board's anode polarity to an active-high enable vector.
  function automatic logic [NUM_DIGITS-1:0] an_drive(input logic [NUM_DIGITS-1:0] an_hi);
    return AN_ACTIVE_LOW ? ~an_hi : an_hi;
  endfunction

  logic [CLK_DIV_BITS-1:0] r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_x;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_act_x;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic                    r_pending;
  logic                    r_frame_start;
  logic [6:0]              r_a_to_g;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [NUM_DIGITS-1:0]   w_an_hi;

  // The last prescaler count ends the slot. Wrapping from the last digit ends the frame.
  assign w_tick = &r_cnt;
  assign w_wrap = w_tick && (r_idx == LAST_IDX);

  // Free-running prescaler: one full count is one digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CLK_DIV_BITS'(1);
    end
  end

  // Digit scan index: steps once per slot. With a single digit it stays at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Pending buffer: every load overwrites it, so the last load before a wrap wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_x  <= '0;
      r_pend_dp <= '0;
    end else if (load) begin
      r_pend_x  <= x;
      r_pend_dp <= dp_in;
    end
  end

  // Active buffer: takes the pending data only at a frame wrap, so every frame is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_x  <= '0;
      r_act_dp <= '0;
    end else if (w_wrap && r_pending) begin
      r_act_x  <= r_pend_x;
      r_act_dp <= r_pend_dp;
    end
  end

  // Pending flag: a load wins over a wrap in the same cycle, because its new data still waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (load) begin
      r_pending <= 1'b1;
    end else if (w_wrap) begin
      r_pending <= 1'b0;
    end
  end

  // Frame marker: high for one cycle, the cycle after the scan returns to digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_wrap;
    end
  end

  // Select the nibble and decimal point of the digit being scanned.
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_act_x[4*i +: 4];
        w_dp_sel    = r_act_dp[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef HEX7SEG_LZ_BLANK_EN
  // Leading-zero mask: scan from the top digit down. Stop suppressing at the first nonzero nibble or set dp.
  always_comb begin
    logic keep;
    keep      = 1'b0;
    w_lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      keep         = keep | (r_act_x[4*i +: 4] != 4'h0) | r_act_dp[i];
      w_lz_mask[i] = ~keep;
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  // Anode enable: off during the blanking window. Otherwise one-hot at the scan index, gated by the live enables.
  always_comb begin
    w_an_hi = w_onehot & digit_en & ~w_lz_mask;
    if (r_cnt < BLANK_LIM) begin
      w_an_hi = '0;
    end
  end

  // Output registers: the pins lag the scan state by one clock and come out glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_to_g <= SEG_OFF;
      r_dp     <= DP_OFF;
      r_an     <= AN_OFF;
    end else begin
      r_a_to_g <= seg_drive(hex_to_seg(w_nib));
      r_dp     <= SEG_ACTIVE_LOW ? ~w_dp_sel : w_dp_sel;
      r_an     <= an_drive(w_an_hi);
    end
  end

  assign a_to_g      = r_a_to_g;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_frame_start;
  assign pending     = r_pending;

endmodule

// File: tb/tb_hex7seg_scan_mux.sv
// Testbench for hex7seg_scan_mux. It uses 4 digits, 8-clock slots, a 2-clock
// blanking window, and active-low segments and anodes. The stimulus process
// loads values and queues the frame each load should produce. The monitor
// process pops one expected frame at each frame_start and checks every
// cycle of that frame on the pins.
module tb_hex7seg_scan_mux;

  localparam int ND  = 4;
  localparam int DIV = 3;
  localparam int BLK = 2;
`ifdef HEX7SEG_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [15:0]   x;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          load;
  logic [6:0]    a_to_g;
  logic          dp;
  logic [3:0]    an;
  logic          frame_start;
  logic          pending;

  hex7seg_scan_mux #(
    .NUM_DIGITS(ND), .CLK_DIV_BITS(DIV), .BLANK_CYCLES(BLK),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .a_to_g(a_to_g), .dp(dp), .an(an),
    .frame_start(frame_start), .pending(pending)
  );

  typedef struct {
    logic [15:0] xv;
    logic [3:0]  dpv;
    logic [3:0]  en;
    logic        pend;
  } frame_t;

  frame_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-entered active-high segment codes.
  function automatic logic [6:0] seg_hi(input logic [3:0] n);
    case (n)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
      4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
    endcase
  endfunction

  // Leading-zero blanking of digit i (only when the optional feature is built).
  function automatic bit lz_blank(input logic [15:0] v, input logic [3:0] d, input int i);
    bit zero_above;
    zero_above = 1'b1;
    for (int j = i; j < ND; j++) begin
      if (v[4*j +: 4] != 4'h0 || d[j]) zero_above = 1'b0;
    end
    return LZ_EN && (i != 0) && zero_above;
  endfunction

  // Monitor: at each frame_start with an expected frame queued, check pending and the next 31 pin samples.
  initial begin
    frame_t e;
    int     fr;
    fr = 0;
    forever begin
      @(negedge clk);
      if (frame_start && q.size() > 0) begin
        e = q.pop_front();
        fr++;
        chk($sformatf("f%0d_pending_at_wrap", fr), 32'(pending), 32'(e.pend));
        for (int k = 1; k < 32; k++) begin
          int         idx;
          int         c;
          logic [3:0] an_exp;
          logic [6:0] seg_exp;
          logic       dp_exp;
          @(negedge clk);
          idx     = (k - 1) / 8;
          c       = (k - 1) % 8;
          an_exp  = 4'hF;
          if (c >= BLK && e.en[idx] && !lz_blank(e.xv, e.dpv, idx)) an_exp[idx] = 1'b0;
          seg_exp = ~seg_hi(e.xv[4*idx +: 4]);
          dp_exp  = ~e.dpv[idx];
          chk($sformatf("f%0d_d%0d_c%0d {fs,an,seg,dp}", fr, idx, c),
              32'({frame_start, an, a_to_g, dp}), 32'({1'b0, an_exp, seg_exp, dp_exp}));
        end
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    x     = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en, input logic p);
    frame_t e;
    e.xv = v; e.dpv = d; e.en = en; e.pend = p;
    q.push_back(e);
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    if (!frame_start) chk({name, "_timeout"}, 32'(n), 32'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; x = '0; dp_in = '0; digit_en = 4'hF; load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_load(16'h5555, 4'h0);
    chk("pending_after_load", 32'(pending), 32'(1));
    repeat (6) @(negedge clk);
    // Async reset mid-scan: pins must drop to the off state without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_an", 32'(an), 32'(4'hF));
    chk("reset_a_to_g", 32'(a_to_g), 32'(7'h7F));
    chk("reset_dp", 32'(dp), 32'(1));
    chk("reset_pending", 32'(pending), 32'(0));
    chk("reset_frame_start", 32'(frame_start), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    // Wrap state is reached after 31 edges. frame_start registers on the 32nd edge and is high in the 33rd cycle.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    chk("first_frame_start_latency", 32'(n), 32'(32));

    // Scan and blanking with 12AF.
    repeat (3) @(negedge clk);
    do_load(16'h12AF, 4'h0);
    push(16'h12AF, 4'h0, 4'hF, 1'b0);
    wait_fs("fs_12af");

    // Two loads in one frame: 1111 is never shown, 2222 is shown after the wrap.
    repeat (3) @(negedge clk);
    do_load(16'h1111, 4'h0);
    chk("pending_after_1111", 32'(pending), 32'(1));
    repeat (5) @(negedge clk);
    do_load(16'h2222, 4'h0);
    push(16'h2222, 4'h0, 4'hF, 1'b0);
    wait_fs("fs_2222");

    // Load 3333, then load 4444 on the exact wrap edge (32 edges after this frame_start).
    repeat (3) @(negedge clk);
    do_load(16'h3333, 4'h0);
    push(16'h3333, 4'h0, 4'hF, 1'b1);
    push(16'h4444, 4'h0, 4'hF, 1'b0);
    repeat (27) @(negedge clk);
    do_load(16'h4444, 4'h0);
    wait_fs("fs_4444");

    // digit_en and decimal points; enables switch exactly on the frame boundary.
    repeat (3) @(negedge clk);
    do_load(16'h8888, 4'b0010);
    push(16'h8888, 4'b0010, 4'b1010, 1'b0);
    wait_fs("fs_8888");
    digit_en = 4'b1010;

    // Leading-zero vectors (dark digits only when the optional feature is built).
    repeat (3) @(negedge clk);
    do_load(16'h0040, 4'h0);
    push(16'h0040, 4'h0, 4'hF, 1'b0);
    wait_fs("fs_0040");
    digit_en = 4'hF;

    repeat (3) @(negedge clk);
    do_load(16'h0000, 4'h0);
    push(16'h0000, 4'h0, 4'hF, 1'b0);
    wait_fs("fs_0000");

    repeat (34) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
